// File: rtl/munchman_pkg.sv
// munchman_pkg: shared constants for the proc_* batch driver.
// Holds the FSM state encoding, result status codes, the result record
// layout and the default match-string length.
package munchman_pkg;

  localparam int HASH_W        = 128;
  localparam int MSG_CHARS_DEF = 19;

  // FSM state encoding; all transmit states have bit 2 set
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_STREAM    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_TX_STATUS = 3'd4;
  localparam logic [2:0] S_TX_POS_HI = 3'd5;
  localparam logic [2:0] S_TX_POS_LO = 3'd6;
  localparam logic [2:0] S_TX_CHAR   = 3'd7;

  // Status byte leading every result record
  localparam logic [7:0] ST_NOMATCH = 8'h00;
  localparam logic [7:0] ST_MATCH   = 8'h01;
  localparam logic [7:0] ST_ERR     = 8'h02;
  localparam logic [7:0] ST_TIMEOUT = 8'h03;

  // Result latched from the matcher before serialisation
  typedef struct packed {
    logic [7:0]  status;
    logic [15:0] byte_pos;
  } result_t;

  // Status byte for a completed batch
  function automatic logic [7:0] match_status(input logic match);
    return match ? ST_MATCH : ST_NOMATCH;
  endfunction

  // True for the states that own the transmit stream
  function automatic logic is_tx_state(input logic [2:0] st);
    return (st == S_TX_STATUS) || (st == S_TX_POS_HI) ||
           (st == S_TX_POS_LO) || (st == S_TX_CHAR);
  endfunction

endpackage

// File: rtl/pbd_tx_serializer.sv
// pbd_tx_serializer: one-byte valid/ready output holding register.
// A byte is loaded only while the register is empty; it is then held
// stable until the sink accepts it. o_load_fire marks the cycle a load
// actually happens, o_accept the cycle the sink takes the byte.
module pbd_tx_serializer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_load_fire,
  output logic       o_accept
);

  logic [7:0] r_data;
  logic       r_valid;

  assign o_load_fire = i_load && !r_valid;
  assign o_accept    = r_valid && i_tx_ready;
  assign o_tx_data   = r_data;
  assign o_tx_valid  = r_valid;

  // Hold the byte until accepted; reload only from the empty state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (o_accept) begin
      r_valid <= 1'b0;
    end else if (o_load_fire) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/proc_batch_driver.sv
// proc_batch_driver: host-side driver for the string_process_match core.
// Takes a batch command, streams the requested number of upstream bytes
// into the matcher, waits for proc_done and sends back a result record:
// status, byte position (hi, lo) and MSG_CHARS match characters on a
// match; only the status byte otherwise.
// Optional WAIT_DONE watchdog: define PBD_TIMEOUT_EN.
module proc_batch_driver
  import munchman_pkg::*;
#(
  parameter int MSG_CHARS      = MSG_CHARS_DEF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic [15:0]       cmd_num_bytes,
  input  logic [HASH_W-1:0] cmd_target_hash,
  output logic              busy,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              proc_start,
  output logic [15:0]       proc_num_bytes,
  output logic [HASH_W-1:0] proc_target_hash,
  output logic [7:0]        proc_data,
  output logic              proc_data_valid,
  output logic              proc_match_char_next,
  input  logic              proc_done,
  input  logic              proc_match,
  input  logic [15:0]       proc_byte_pos,
  input  logic [7:0]        proc_match_char,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int CHAR_W = (MSG_CHARS > 1) ? $clog2(MSG_CHARS) : 1;
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(MSG_CHARS - 1);

  logic [2:0]        r_state;
  logic [15:0]       r_num_bytes;
  logic [HASH_W-1:0] r_target_hash;
  logic [15:0]       r_rem_cnt;
  logic [CHAR_W-1:0] r_char_cnt;
  result_t           r_result;
  logic [7:0]        r_proc_data;
  logic              r_proc_data_valid;

  logic              w_in_fire;
  logic              w_tx_load;
  logic [7:0]        w_tx_load_data;
  logic              w_tx_load_fire;
  logic              w_tx_accept;
  logic              w_timeout;

  assign busy             = (r_state != S_IDLE);
  assign in_ready         = (r_state == S_STREAM);
  assign proc_start       = (r_state == S_START);
  assign proc_num_bytes   = r_num_bytes;
  assign proc_target_hash = r_target_hash;
  assign proc_data        = r_proc_data;
  assign proc_data_valid  = r_proc_data_valid;
  assign w_in_fire        = in_valid && in_ready;

  // The matcher shifts its string on the same edge the current char is
  // captured, so the strobe follows the serializer's load in TX_CHAR
  assign proc_match_char_next = (r_state == S_TX_CHAR) && w_tx_load_fire;
  assign w_tx_load            = is_tx_state(r_state);

  // Byte offered to the serializer in each transmit state
  always_comb begin
    w_tx_load_data = 8'h00;
    case (r_state)
      S_TX_STATUS: w_tx_load_data = r_result.status;
      S_TX_POS_HI: w_tx_load_data = r_result.byte_pos[15:8];
      S_TX_POS_LO: w_tx_load_data = r_result.byte_pos[7:0];
      S_TX_CHAR:   w_tx_load_data = proc_match_char;
      default:     w_tx_load_data = 8'h00;
    endcase
  end

  pbd_tx_serializer u_tx (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_tx_load),
    .i_data      (w_tx_load_data),
    .i_tx_ready  (tx_ready),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .o_load_fire (w_tx_load_fire),
    .o_accept    (w_tx_accept)
  );

`ifdef PBD_TIMEOUT_EN
  logic [15:0] r_wd_cnt;

  // Watchdog: counts cycles spent in WAIT_DONE, zero everywhere else
  always_ff @(posedge clk) begin
    if (!reset_n || (r_state != S_WAIT_DONE)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  // Batch FSM: command capture, byte streaming, result latch, record sequencing
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_num_bytes       <= '0;
      r_target_hash     <= '0;
      r_rem_cnt         <= '0;
      r_char_cnt        <= '0;
      r_result          <= '0;
      r_proc_data       <= '0;
      r_proc_data_valid <= 1'b0;
    end else begin
      // Data strobe is only high the cycle after an upstream handshake
      r_proc_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_num_bytes != 16'd0) begin
              r_num_bytes   <= cmd_num_bytes;
              r_target_hash <= cmd_target_hash;
              r_state       <= S_START;
            end else begin
              r_result.status <= ST_ERR;
              r_state         <= S_TX_STATUS;
            end
          end
        end
        S_START: begin
          r_rem_cnt <= r_num_bytes;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          if (w_in_fire) begin
            r_proc_data       <= in_data;
            r_proc_data_valid <= 1'b1;
            r_rem_cnt         <= r_rem_cnt - 16'd1;
            if (r_rem_cnt == 16'd1) begin
              r_state <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (proc_done) begin
            r_result.status   <= match_status(proc_match);
            r_result.byte_pos <= proc_byte_pos;
            r_state           <= S_TX_STATUS;
          end else if (w_timeout) begin
            r_result.status <= ST_TIMEOUT;
            r_state         <= S_TX_STATUS;
          end
        end
        S_TX_STATUS: begin
          if (w_tx_accept) begin
            r_state <= (r_result.status == ST_MATCH) ? S_TX_POS_HI : S_IDLE;
          end
        end
        S_TX_POS_HI: begin
          if (w_tx_accept) begin
            r_state <= S_TX_POS_LO;
          end
        end
        S_TX_POS_LO: begin
          if (w_tx_accept) begin
            r_char_cnt <= '0;
            r_state    <= S_TX_CHAR;
          end
        end
        S_TX_CHAR: begin
          if (w_tx_accept) begin
            if (r_char_cnt == LAST_CHAR) begin
              r_state <= S_IDLE;
            end else begin
              r_char_cnt <= r_char_cnt + CHAR_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
